mmm_mac_sequencer: RTL and testbench
====================================

Name: mmm_mac_sequencer

Overview:
- Control-side counterpart of the pipelined saturating MAC used in the matrix-matrix multiply datapath.
- Reads matrix A (MxK) and matrix B (KxN) from two synchronous-read RAMs and drives the MAC's in0/in1/valid_input/clear_acc pins.
- Collects each finished dot product from the MAC output and emits C = A*B, row-major, on a valid/ready output stream.

Parameters:
- INW, 16, element width of A and B
- OUTW, 48, MAC accumulator and output element width
- M, 4, rows of A and C (minimum 2)
- K, 4, inner dimension (minimum 2)
- N, 4, columns of B and C (minimum 2)
- AW_A, $clog2(M*K), A address width (derived)
- AW_B, $clog2(K*N), B address width (derived)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start_valid  input  1  request to compute one product
- start_ready  output  1  high only in IDLE
- addr_a  output  AW_A  A RAM read address; A row-major, element (i,k) at i*K+k
- addr_b  output  AW_B  B RAM read address; B row-major, element (k,j) at k*N+j
- data_a  input  INW  A RAM read data, valid 1 cycle after addr_a
- data_b  input  INW  B RAM read data, valid 1 cycle after addr_b
- mac_in0  output  INW  combinational copy of data_a
- mac_in1  output  INW  combinational copy of data_b
- mac_valid_input  output  1  MAC product-accept strobe
- mac_clear_acc  output  1  MAC accumulator restart
- mac_out  input  OUTW  MAC accumulator value
- output_data  output  OUTW  C element
- output_valid  output  1  C element valid
- output_ready  input  1  downstream accept

Behaviour:
- Reset: state=IDLE, i=j=k=0, addr_a=addr_b=0, mac_valid_input=0, mac_clear_acc=0, output_valid=0. All pipeline flags are cleared.
- Reset mid-operation: aborts immediately with no partial output. It does not drive the MAC reset.
- FSM states: IDLE, ISSUE, DRAIN, OUTPUT.
- IDLE:
  - start_ready=1.
  - A cycle with start_valid&start_ready accepts the request: i=j=k=0, next state ISSUE.
- ISSUE:
  - Each cycle presents addr_a=i*K+k and addr_b=k*N+j, sets the internal issue flag, and increments k.
  - After k=K-1 is issued: k returns to 0, next state DRAIN.
  - Exactly K cycles per element.
- Pipeline alignment (issue in cycle t):
  - mac_valid_input=1 in cycle t+1 (registered issue flag).
  - mac_clear_acc=1 in cycle t+2, only for the k=0 issue (2-stage delayed first-term flag).
  - mac_valid_input is 0 in every cycle not following an issue.
  - mac_clear_acc is 0 except for the single cycle above.
- DRAIN: exactly 2 cycles, then OUTPUT. mac_out holds the full sum from cycle t_last+3 onward.
- OUTPUT:
  - output_valid=1 and output_data=mac_out (stable, because the MAC adds 0 while valid_input=0).
  - On output_valid&output_ready:
    - if i=M-1 and j=N-1: go IDLE;
    - else: j++ (wrap to 0 with i++), go ISSUE.
  - output_data is not required to be stable outside OUTPUT.
- Cost per element: K+2 cycles, plus one or more OUTPUT cycles depending on backpressure.
- start_valid is ignored outside IDLE.
- Saturation is the MAC's responsibility; the sequencer passes mac_out through unmodified.

Optional Feature:
- Macro: MMM_SEQ_PERF_EN.
- Defined:
  - Adds output port perf_cycles (32 bits).
  - Counter clears to 0 on reset and on request accept.
  - Increments every cycle the state is not IDLE; holds its value in IDLE; saturates at 2^32-1.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Baseline product, M=K=N=2, output_ready held 1: A=[[1,2],[3,4]], B=[[5,6],[7,8]], start pulse -> outputs 19, 22, 43, 50 in order; start_ready=1 again the cycle after the 4th handshake; perf_cycles=20 when the feature is enabled.
- Backpressure: same data, output_ready=0 for 5 cycles on the 2nd element -> output_valid stays 1 and output_data stays 22 throughout; no new addresses are issued; the sequence completes correctly.
- MAC strobes: same data -> for each element, exactly 2 mac_valid_input pulses, 1 cycle after their addresses; one mac_clear_acc pulse 2 cycles after the k=0 address; no clear in any other cycle.
- Signed and saturation pass-through: A=[[-32768,-32768],[1,0]], B=[[-32768,0],[-32768,0]] -> C[0][0]=2^31 (no MAC saturation at OUTW=48); negative values propagate unmodified, e.g. A row 0 = [-1,-1] with B column 0 = [5,7] -> -12.
- Reset mid-run: reset during ISSUE of element 2 -> next cycle is IDLE with start_ready=1 and all MAC strobes 0; a fresh start produces the full 19, 22, 43, 50 sequence.
- Start while busy: start_valid held 1 through a run -> exactly one run per accept; the second accept occurs only after the last output handshake.

Source files
------------

// File: rtl/mmm_mac_sequencer.sv
// mmm_mac_sequencer
//   Control side of the matrix-matrix multiply datapath. It walks A (MxK) and
//   B (KxN), which sit in two synchronous-read RAMs, and drives the pins of a
//   pipelined saturating MAC. Each finished dot product is sent out, row-major,
//   on a valid/ready stream as one element of C = A*B.
//
//   Optional build macro: MMM_SEQ_PERF_EN adds the perf_cycles port, which
//   counts busy cycles.
//
//   Ports
//     clk, reset           clock, synchronous active-high reset
//     start_valid/ready    request handshake; ready only while idle
//     addr_a, addr_b       RAM read addresses (A at i*K+k, B at k*N+j)
//     data_a, data_b       RAM read data, one cycle after the address
//     mac_in0, mac_in1     operands to the MAC (RAM data passed straight through)
//     mac_valid_input      MAC product-accept strobe
//     mac_clear_acc        MAC accumulator restart
//     mac_out              MAC accumulator value
//     output_data/valid    C element stream
//     output_ready         downstream accept
//     perf_cycles          busy-cycle count (MMM_SEQ_PERF_EN only)
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | waiting for start_valid
//   S_ISSUE  | one A/B address pair per cycle, k = 0..K-1
//   S_DRAIN  | 2 cycles so the MAC pipeline finishes the last term
//   S_OUTPUT | C element valid, held until the downstream accepts it

module mmm_mac_sequencer #(
    parameter int INW  = 16,
    parameter int OUTW = 48,
    parameter int M    = 4,
    parameter int K    = 4,
    parameter int N    = 4,
    parameter int AW_A = $clog2(M*K),
    parameter int AW_B = $clog2(K*N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_valid,
    output logic            start_ready,
    output logic [AW_A-1:0] addr_a,
    output logic [AW_B-1:0] addr_b,
    input  logic [INW-1:0]  data_a,
    input  logic [INW-1:0]  data_b,
    output logic [INW-1:0]  mac_in0,
    output logic [INW-1:0]  mac_in1,
    output logic            mac_valid_input,
    output logic            mac_clear_acc,
    input  logic [OUTW-1:0] mac_out,
    output logic [OUTW-1:0] output_data,
    output logic            output_valid,
    input  logic            output_ready
`ifdef MMM_SEQ_PERF_EN
    ,
    output logic [31:0]     perf_cycles
`endif
);

    localparam int IW = $clog2(M);
    localparam int JW = $clog2(N);
    localparam int KW = $clog2(K);

    localparam logic [IW-1:0]   I_LAST   = IW'(M-1);
    localparam logic [JW-1:0]   J_LAST   = JW'(N-1);
    localparam logic [KW-1:0]   K_LAST   = KW'(K-1);
    localparam logic [AW_A-1:0] A_STRIDE = AW_A'(K);
    localparam logic [AW_B-1:0] B_STRIDE = AW_B'(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUTPUT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_i;
    logic [JW-1:0]   r_j;
    logic [KW-1:0]   r_k;
    logic            r_issue;
    logic            r_first_d1;
    logic            r_first_d2;
    logic            r_drain;
    logic            w_accept;
    logic            w_out_fire;
    logic            w_last_k;
    logic            w_last_elem;

    assign w_accept    = (r_state == S_IDLE) && start_valid;
    assign w_out_fire  = (r_state == S_OUTPUT) && output_ready;
    assign w_last_k    = (r_k == K_LAST);
    assign w_last_elem = (r_i == I_LAST) && (r_j == J_LAST);

    // Addresses are only meaningful while issuing; parking them at 0 elsewhere
    // keeps the RAM ports quiet during drain and backpressure.
    assign addr_a = (r_state == S_ISSUE) ? (AW_A'(r_i) * A_STRIDE + AW_A'(r_k)) : '0;
    assign addr_b = (r_state == S_ISSUE) ? (AW_B'(r_k) * B_STRIDE + AW_B'(r_j)) : '0;

    assign mac_in0         = data_a;
    assign mac_in1         = data_b;
    assign mac_valid_input = r_issue;
    assign mac_clear_acc   = r_first_d2;
    assign output_data     = mac_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        start_ready  = 1'b0;
        output_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_last_k) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain) begin
                    w_state_nxt = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                output_valid = 1'b1;
                if (output_ready) begin
                    w_state_nxt = w_last_elem ? S_IDLE : S_ISSUE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Issue in cycle t: the RAM answers in t+1, so the accept strobe is the
    // issue flag delayed once; the MAC folds the product in at t+2, which is
    // where the first-term flag restarts the accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_issue    <= 1'b0;
            r_first_d1 <= 1'b0;
            r_first_d2 <= 1'b0;
            r_drain    <= 1'b0;
        end else begin
            r_issue    <= (r_state == S_ISSUE);
            r_first_d1 <= (r_state == S_ISSUE) && (r_k == '0);
            r_first_d2 <= r_first_d1;
            r_drain    <= (r_state == S_DRAIN) && !r_drain;
            if (w_accept) begin
                r_i <= '0;
                r_j <= '0;
                r_k <= '0;
            end else if (r_state == S_ISSUE) begin
                r_k <= w_last_k ? '0 : r_k + KW'(1);
            end else if (w_out_fire) begin
                if (w_last_elem) begin
                    r_i <= '0;
                    r_j <= '0;
                end else if (r_j == J_LAST) begin
                    r_j <= '0;
                    r_i <= r_i + IW'(1);
                end else begin
                    r_j <= r_j + JW'(1);
                end
            end
        end
    end

`ifdef MMM_SEQ_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk) begin
        if (reset || w_accept) begin
            r_perf <= '0;
        end else if ((r_state != S_IDLE) && (r_perf != '1)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_mmm_mac_sequencer.sv
// Bench for mmm_mac_sequencer at M=K=N=2. Surrounds the sequencer with a
// registered-read RAM pair and a behavioural 2-stage MAC, and compares the C
// stream and the MAC strobes against products computed directly from A and B.
module tb_mmm_mac_sequencer;

    localparam int INW  = 16;
    localparam int OUTW = 48;
    localparam int M    = 2;
    localparam int K    = 2;
    localparam int N    = 2;
    localparam int AW_A = $clog2(M*K);
    localparam int AW_B = $clog2(K*N);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset        = 1'b1;
    logic            start_valid  = 1'b0;
    logic            output_ready = 1'b0;
    logic            start_ready;
    logic [AW_A-1:0] addr_a;
    logic [AW_B-1:0] addr_b;
    logic [INW-1:0]  data_a = '0;
    logic [INW-1:0]  data_b = '0;
    logic [INW-1:0]  mac_in0;
    logic [INW-1:0]  mac_in1;
    logic            mac_valid_input;
    logic            mac_clear_acc;
    logic [OUTW-1:0] mac_out;
    logic [OUTW-1:0] output_data;
    logic            output_valid;
`ifdef MMM_SEQ_PERF_EN
    logic [31:0]     perf_cycles;
`endif

    mmm_mac_sequencer #(
        .INW(INW), .OUTW(OUTW), .M(M), .K(K), .N(N), .AW_A(AW_A), .AW_B(AW_B)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .addr_a(addr_a),
        .addr_b(addr_b),
        .data_a(data_a),
        .data_b(data_b),
        .mac_in0(mac_in0),
        .mac_in1(mac_in1),
        .mac_valid_input(mac_valid_input),
        .mac_clear_acc(mac_clear_acc),
        .mac_out(mac_out),
        .output_data(output_data),
        .output_valid(output_valid),
        .output_ready(output_ready)
`ifdef MMM_SEQ_PERF_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    // RAMs with one cycle of read latency
    logic [INW-1:0] mem_a [M*K];
    logic [INW-1:0] mem_b [K*N];

    always @(posedge clk) begin
        data_a <= mem_a[addr_a];
        data_b <= mem_b[addr_b];
    end

    // MAC: product registered on valid_input, accumulated one cycle later,
    // clear_acc restarts the sum with the product arriving in that cycle.
    // Test values stay far from the 48-bit rails, so no saturation logic here.
    logic signed [OUTW-1:0] mac_prod = '0;
    logic signed [OUTW-1:0] mac_acc  = '0;
    logic                   mac_pv   = 1'b0;

    always @(posedge clk) begin
        if (mac_valid_input) mac_prod <= OUTW'($signed(mac_in0)) * OUTW'($signed(mac_in1));
        mac_pv  <= mac_valid_input;
        mac_acc <= (mac_clear_acc ? 48'sd0 : mac_acc) + (mac_pv ? mac_prod : 48'sd0);
    end
    assign mac_out = mac_acc;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference: C = A*B straight from the matrices
    logic [OUTW-1:0] exp_c [M*N];

    task automatic build_expected();
        for (int e = 0; e < M*N; e++) begin
            longint s;
            s = 0;
            for (int kk = 0; kk < K; kk++) begin
                s += longint'($signed(mem_a[(e/N)*K+kk])) * longint'($signed(mem_b[kk*N+(e%N)]));
            end
            exp_c[e] = OUTW'(s);
        end
    endtask

    // Monitor state, sampled on the falling edge
    bit              mon_en     = 1'b0;
    int              out_idx    = 0;
    int              pulse_cnt  = 0;
    int              stall_cnt  = 0;
    int              accepts    = 0;
    bit              prev_k0    = 1'b0;
    bit              prev_stall = 1'b0;
    logic [AW_A-1:0] prev_addr_a = '0;
    logic [AW_B-1:0] prev_addr_b = '0;

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (start_valid && start_ready) accepts++;
            check("clear_acc", 64'(mac_clear_acc), 64'(prev_k0));
            if (mac_valid_input) begin
                int e;
                int kk;
                e  = pulse_cnt / K;
                kk = pulse_cnt % K;
                if (e < M*N) begin
                    check("mac_in0", 64'(mac_in0), 64'(mem_a[(e/N)*K+kk]));
                    check("mac_in1", 64'(mac_in1), 64'(mem_b[kk*N+(e%N)]));
                end else begin
                    check("pulse_overrun", 64'(pulse_cnt), 64'(M*N*K-1));
                end
                prev_k0 = (kk == 0);
                pulse_cnt++;
            end else begin
                prev_k0 = 1'b0;
            end
            if (output_valid) begin
                check("no_issue_in_output", 64'(mac_valid_input), 64'(0));
                if (out_idx < M*N) check("out_data", 64'(output_data), 64'(exp_c[out_idx]));
                else               check("extra_output", 64'(out_idx), 64'(M*N-1));
                if (prev_stall) begin
                    check("addr_a_held", 64'(addr_a), 64'(prev_addr_a));
                    check("addr_b_held", 64'(addr_b), 64'(prev_addr_b));
                end
                prev_addr_a = addr_a;
                prev_addr_b = addr_b;
                prev_stall  = !output_ready;
                if (output_ready) out_idx++;
                else              stall_cnt++;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_start_ready"}, 64'(start_ready), 64'(1));
        check({tag, "_valid_input"}, 64'(mac_valid_input), 64'(0));
        check({tag, "_clear_acc"}, 64'(mac_clear_acc), 64'(0));
        check({tag, "_output_valid"}, 64'(output_valid), 64'(0));
    endtask

    // Called at posedge+1; returns at posedge+1
    task automatic do_reset();
        mon_en       = 1'b0;
        reset        = 1'b1;
        start_valid  = 1'b0;
        output_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic set_mats(input int a0, input int a1, input int a2, input int a3,
                            input int b0, input int b1, input int b2, input int b3);
        mem_a[0] = INW'(a0); mem_a[1] = INW'(a1); mem_a[2] = INW'(a2); mem_a[3] = INW'(a3);
        mem_b[0] = INW'(b0); mem_b[1] = INW'(b1); mem_b[2] = INW'(b2); mem_b[3] = INW'(b3);
    endtask

    // mode 0: ready held 1; mode 1: 5 stall cycles on element bp_elem;
    // mode 2: random ready. Called and returns at posedge+1.
    task automatic run_product(input int mode, input int bp_elem, input bit hold_start, input bit abort_mid);
        int cyc;
        build_expected();
        out_idx    = 0;
        pulse_cnt  = 0;
        stall_cnt  = 0;
        accepts    = 0;
        prev_k0    = 1'b0;
        prev_stall = 1'b0;
        mon_en     = 1'b1;
        start_valid  = 1'b1;
        output_ready = (mode != 2) ? 1'b1 : 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        if (!hold_start) start_valid = 1'b0;
        cyc = 0;
        while (out_idx < M*N && cyc < 400) begin
            if (abort_mid && out_idx == 1) begin
                mon_en = 1'b0;
                reset  = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
                @(negedge clk);
                check_idle("abort");
                @(posedge clk);
                #1;
                return;
            end
            case (mode)
                1:       output_ready = !(out_idx == bp_elem && stall_cnt < 5);
                2:       output_ready = 1'($urandom_range(0, 1));
                default: output_ready = 1'b1;
            endcase
            @(posedge clk);
            #1;
            cyc++;
        end
        check("run_complete", 64'(out_idx), 64'(M*N));
        check("mac_pulses", 64'(pulse_cnt), 64'(M*N*K));
        if (mode == 1) check("stall_cycles", 64'(stall_cnt), 64'(5));
        @(negedge clk);
        #1;
        check("start_ready_after", 64'(start_ready), 64'(1));
`ifdef MMM_SEQ_PERF_EN
        check("perf_cycles", 64'(perf_cycles), 64'(M*N*(K+3) + stall_cnt));
`endif
        check("accepts", 64'(accepts), hold_start ? 64'(2) : 64'(1));
        mon_en = 1'b0;
        if (hold_start) begin
            do_reset();
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_mats(1, 2, 3, 4, 5, 6, 7, 8);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        check("reset_addr_a", 64'(addr_a), 64'(0));
        check("reset_addr_b", 64'(addr_b), 64'(0));
`ifdef MMM_SEQ_PERF_EN
        check("reset_perf", 64'(perf_cycles), 64'(0));
`endif
        @(posedge clk);
        #1 reset = 1'b0;

        // baseline 19, 22, 43, 50
        run_product(0, 0, 1'b0, 1'b0);
        // backpressure on the 2nd element
        run_product(1, 1, 1'b0, 1'b0);
        // signed extremes: C[0][0] = 2^31
        set_mats(-32768, -32768, 1, 0, -32768, 0, -32768, 0);
        run_product(0, 0, 1'b0, 1'b0);
        // negative propagation: row 0 [-1,-1] x col 0 [5,7] = -12
        set_mats(-1, -1, 3, 4, 5, 6, 7, 8);
        run_product(2, 0, 1'b0, 1'b0);
        // reset mid-run, then a fresh full run
        set_mats(1, 2, 3, 4, 5, 6, 7, 8);
        run_product(0, 0, 1'b0, 1'b1);
        run_product(0, 0, 1'b0, 1'b0);
        // start held high through a run
        run_product(0, 0, 1'b1, 1'b0);
        // random matrices with random backpressure
        for (int t = 0; t < 10; t++) begin
            for (int x = 0; x < M*K; x++) mem_a[x] = INW'($urandom);
            for (int x = 0; x < K*N; x++) mem_b[x] = INW'($urandom);
            run_product((t % 2 == 0) ? 2 : 1, t % (M*N), 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
